// File: rtl/pool_wb_pkg.sv
// Shared types for the pooling write-back descriptor generator:
// descriptor record, FSM state encoding and the descriptors-per-sub-batch helper.
package pool_wb_pkg;

    // Address field is sized for the largest supported RTM; users truncate to their AW.
    localparam int DESC_AW = 32;

    typedef struct packed {
        logic [DESC_AW-1:0] addr;
        logic               mask;
        logic               last;
    } pool_wb_desc_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } pool_wb_state_e;

    function automatic int pool_wb_n1(input int p, input int r);
        return p / r;
    endfunction

endpackage

// File: rtl/pool_wb_addr_pipe.sv
// Stallable address pipeline: stage 1 is the counter state owned by the caller,
// stage 2 forms the base sum, stage 3 adds the sub-batch index and drives the output.
module pool_wb_addr_pipe
    import pool_wb_pkg::*;
#(
    parameter int AW = 13,
    parameter int CW = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [AW-1:0] in_y_addr,
    input  logic [AW-1:0] in_chan_base,
    input  logic [AW-1:0] in_fm_base,
    input  logic [CW-1:0] in_n1,
    input  logic          in_mask,
    input  logic          in_last,
    output logic          out_valid,
    input  logic          out_ready,
    output pool_wb_desc_t out_desc
);

    logic          s2_valid_reg;
    logic [AW-1:0] s2_base_reg;
    logic [CW-1:0] s2_n1_reg;
    logic          s2_mask_reg;
    logic          s2_last_reg;
    logic          s3_valid_reg;
    pool_wb_desc_t s3_desc_reg;

    logic          s3_take;
    logic [AW-1:0] s3_addr_next;

    // A stage accepts new data when it is empty or its content is leaving this cycle.
    assign s3_take      = !s3_valid_reg || out_ready;
    assign in_ready     = !s2_valid_reg || s3_take;
    // Kept at AW bits so the sum wraps modulo the RTM depth.
    assign s3_addr_next = s2_base_reg + AW'(s2_n1_reg);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_reg <= 1'b0;
            s2_base_reg  <= '0;
            s2_n1_reg    <= '0;
            s2_mask_reg  <= 1'b0;
            s2_last_reg  <= 1'b0;
            s3_valid_reg <= 1'b0;
            s3_desc_reg  <= '0;
        end else if (flush) begin
            s2_valid_reg <= 1'b0;
            s3_valid_reg <= 1'b0;
        end else begin
            if (in_ready) begin
                s2_valid_reg <= in_valid;
                if (in_valid) begin
                    s2_base_reg <= in_y_addr + in_chan_base + in_fm_base;
                    s2_n1_reg   <= in_n1;
                    s2_mask_reg <= in_mask;
                    s2_last_reg <= in_last;
                end
            end
            if (s3_take) begin
                s3_valid_reg <= s2_valid_reg;
                if (s2_valid_reg) begin
                    s3_desc_reg.addr <= DESC_AW'(s3_addr_next);
                    s3_desc_reg.mask <= s2_mask_reg;
                    s3_desc_reg.last <= s2_last_reg;
                end
            end
        end
    end

    assign out_valid = s3_valid_reg;
    assign out_desc  = s3_desc_reg;

endmodule

// File: rtl/pool_wb_desc_gen.sv
// Write-back descriptor generator: walks the (x-round, channel-increment, sub-batch)
// loop nest of one pooling instruction and streams RTM write descriptors.
module pool_wb_desc_gen
    import pool_wb_pkg::*;
#(
    parameter int P         = 16,
    parameter int R         = 4,
    parameter int RTM_DEPTH = 8192
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic                         abort,
    input  logic [$clog2(RTM_DEPTH)-1:0] Y_addr,
    input  logic [15:0]                  INC2_minus_1,
    input  logic [15:0]                  n_X_rnd_minus_1,
    input  logic [15:0]                  ofm_height,
    input  logic [7:0]                   n_last_batch,
    output logic                         desc_valid,
    input  logic                         desc_ready,
    output logic [$clog2(RTM_DEPTH)-1:0] desc_addr,
    output logic                         desc_mask,
    output logic                         desc_last,
    output logic                         busy,
    output logic                         done
);

    localparam int N1   = pool_wb_n1(P, R);
    localparam int CW   = $clog2(N1 + 1);
    localparam int AW   = $clog2(RTM_DEPTH);
    localparam int CMPW = (CW > 8) ? CW : 8;
    localparam logic [CW-1:0] N1_LAST = CW'(N1 - 1);
    localparam logic [AW-1:0] N1_AW   = AW'(N1);

    pool_wb_state_e state_reg, state_next;
    logic           done_reg, done_next;

    logic [AW-1:0]  y_addr_reg;
    logic [AW-1:0]  ofm_height_reg;
    logic [15:0]    inc_max_reg;
    logic [15:0]    x_max_reg;
    logic [7:0]     n_last_reg;

    logic [CW-1:0]  n1_reg;
    logic [15:0]    inc_reg;
    logic [15:0]    x_reg;
    logic [AW-1:0]  chan_base_reg;
    logic [AW-1:0]  fm_base_reg;

    logic           start_ok;
    logic           s1_valid;
    logic           s1_ready;
    logic           s1_fire;
    logic           n1_wrap;
    logic           inc_wrap;
    logic           x_final;
    logic           tuple_last;
    logic           s1_mask;
    logic           out_valid;
    pool_wb_desc_t  out_desc;
    logic           hs_last;

    assign start_ok   = (state_reg == ST_IDLE) && start && !abort;
    assign s1_valid   = (state_reg == ST_RUN);
    assign s1_fire    = s1_valid && s1_ready;
    assign n1_wrap    = (n1_reg == N1_LAST);
    assign inc_wrap   = (inc_reg == inc_max_reg);
    assign x_final    = (x_reg == x_max_reg);
    assign tuple_last = n1_wrap && inc_wrap && x_final;
    assign s1_mask    = x_final && (CMPW'(n1_reg) >= CMPW'(n_last_reg));
    assign hs_last    = out_valid && desc_ready && out_desc.last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            done_reg  <= done_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        done_next  = 1'b0;
        case (state_reg)
            ST_IDLE:  if (start_ok) state_next = ST_RUN;
            ST_RUN:   if (s1_fire && tuple_last) state_next = ST_DRAIN;
            ST_DRAIN: begin
                if (hs_last) begin
                    state_next = ST_IDLE;
                    done_next  = 1'b1;
                end
            end
            default:  state_next = ST_IDLE;
        endcase
        // Abort wins over everything, including the completion pulse.
        if (abort) begin
            state_next = ST_IDLE;
            done_next  = 1'b0;
        end
    end

    // Loop counters and running address bases; they only move when stage 1 hands off.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_addr_reg     <= '0;
            ofm_height_reg <= '0;
            inc_max_reg    <= '0;
            x_max_reg      <= '0;
            n_last_reg     <= '0;
            n1_reg         <= '0;
            inc_reg        <= '0;
            x_reg          <= '0;
            chan_base_reg  <= '0;
            fm_base_reg    <= '0;
        end else if (start_ok) begin
            y_addr_reg     <= Y_addr;
            ofm_height_reg <= AW'(ofm_height);
            inc_max_reg    <= INC2_minus_1;
            x_max_reg      <= n_X_rnd_minus_1;
            n_last_reg     <= n_last_batch;
            n1_reg         <= '0;
            inc_reg        <= '0;
            x_reg          <= '0;
            chan_base_reg  <= '0;
            fm_base_reg    <= '0;
        end else if (s1_fire) begin
            if (!n1_wrap) begin
                n1_reg <= n1_reg + 1'b1;
            end else begin
                n1_reg <= '0;
                if (!inc_wrap) begin
                    inc_reg       <= inc_reg + 16'd1;
                    chan_base_reg <= chan_base_reg + ofm_height_reg;
                end else begin
                    inc_reg       <= '0;
                    chan_base_reg <= '0;
                    x_reg         <= x_reg + 16'd1;
                    fm_base_reg   <= fm_base_reg + N1_AW;
                end
            end
        end
    end

    pool_wb_addr_pipe #(
        .AW (AW),
        .CW (CW)
    ) u_pipe (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (abort),
        .in_valid     (s1_valid),
        .in_ready     (s1_ready),
        .in_y_addr    (y_addr_reg),
        .in_chan_base (chan_base_reg),
        .in_fm_base   (fm_base_reg),
        .in_n1        (n1_reg),
        .in_mask      (s1_mask),
        .in_last      (tuple_last),
        .out_valid    (out_valid),
        .out_ready    (desc_ready),
        .out_desc     (out_desc)
    );

    assign desc_valid = out_valid;
    assign desc_addr  = AW'(out_desc.addr);
    assign desc_mask  = out_desc.mask;
    assign desc_last  = out_desc.last;
    assign busy       = (state_reg != ST_IDLE);
    assign done       = done_reg;

endmodule

// File: tb/tb_pool_wb_desc_gen.sv
// Bench for pool_wb_desc_gen: table-driven directed runs, stall/abort/reset corners,
// and random instructions checked against a loop-nest reference model.
module tb_pool_wb_desc_gen;

    localparam int D  = 8192;
    localparam int AW = $clog2(D);

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          sel   = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          ready = 1'b0;
    logic [AW-1:0] y_addr = '0;
    logic [15:0]   inc2m1 = '0;
    logic [15:0]   nxm1   = '0;
    logic [15:0]   ofm_h  = '0;
    logic [7:0]    n_last = '0;

    logic          start_a, abort_a, start_b, abort_b;
    logic          valid_a, mask_a, last_a, busy_a, done_a;
    logic          valid_b, mask_b, last_b, busy_b, done_b;
    logic [AW-1:0] addr_a, addr_b;
    logic          m_valid, m_mask, m_last, m_busy, m_done;
    logic [AW-1:0] m_addr;

    assign start_a = start & ~sel;
    assign abort_a = abort & ~sel;
    assign start_b = start & sel;
    assign abort_b = abort & sel;

    pool_wb_desc_gen #(.P(8), .R(4), .RTM_DEPTH(D)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a),
        .Y_addr(y_addr), .INC2_minus_1(inc2m1), .n_X_rnd_minus_1(nxm1),
        .ofm_height(ofm_h), .n_last_batch(n_last),
        .desc_valid(valid_a), .desc_ready(ready), .desc_addr(addr_a),
        .desc_mask(mask_a), .desc_last(last_a), .busy(busy_a), .done(done_a)
    );

    pool_wb_desc_gen #(.P(4), .R(4), .RTM_DEPTH(D)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b),
        .Y_addr(y_addr), .INC2_minus_1(inc2m1), .n_X_rnd_minus_1(nxm1),
        .ofm_height(ofm_h), .n_last_batch(n_last),
        .desc_valid(valid_b), .desc_ready(ready), .desc_addr(addr_b),
        .desc_mask(mask_b), .desc_last(last_b), .busy(busy_b), .done(done_b)
    );

    assign m_valid = sel ? valid_b : valid_a;
    assign m_addr  = sel ? addr_b  : addr_a;
    assign m_mask  = sel ? mask_b  : mask_a;
    assign m_last  = sel ? last_b  : last_a;
    assign m_busy  = sel ? busy_b  : busy_a;
    assign m_done  = sel ? done_b  : done_a;

    typedef struct {
        int addr;
        bit mask;
        bit last;
    } exp_t;

    exp_t expq[$];
    exp_t tab1[8];
    exp_t tab3[4];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Reference: enumerate the loop nest directly with plain arithmetic.
    task automatic build_model(input int n1);
        exp_t e;
        int   y, ih, xm, oh, nl;
        y  = int'(y_addr);
        ih = int'(inc2m1);
        xm = int'(nxm1);
        oh = int'(ofm_h);
        nl = int'(n_last);
        expq.delete();
        for (int x = 0; x <= xm; x++)
            for (int inc = 0; inc <= ih; inc++)
                for (int k = 0; k < n1; k++) begin
                    e.addr = (y + inc * oh + x * n1 + k) % D;
                    e.mask = (x == xm) && (k >= nl);
                    e.last = (x == xm) && (inc == ih) && (k == n1 - 1);
                    expq.push_back(e);
                end
    endtask

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Entered at the first negedge after the start edge; consumes expq.
    task automatic drain(input int rdy_pct, input int pulse_at, input string tag);
        int            cyc, first_cyc, r;
        bit            got_last, stalled;
        logic [AW-1:0] h_addr;
        logic          h_mask, h_last;
        exp_t          e;
        cyc = 0; first_cyc = -1; got_last = 1'b0; stalled = 1'b0;
        h_addr = '0; h_mask = 1'b0; h_last = 1'b0;
        chk({tag, "_busy_start"}, int'(m_busy), 1);
        while (!got_last && cyc < 2000) begin
            if (first_cyc < 0 && m_valid) first_cyc = cyc;
            if (stalled) begin
                chk({tag, "_stall_valid"}, int'(m_valid), 1);
                chk({tag, "_stall_addr"}, int'(m_addr), int'(h_addr));
                chk({tag, "_stall_flags"}, int'({m_mask, m_last}), int'({h_mask, h_last}));
            end
            if (pulse_at >= 0) begin
                start = (cyc == pulse_at);
                if (cyc == pulse_at) begin
                    y_addr = AW'($urandom);
                    ofm_h  = 16'($urandom);
                end
            end
            r = $urandom_range(0, 99);
            ready = (r < rdy_pct);
            if (m_valid && ready) begin
                if (expq.size() == 0) begin
                    chk({tag, "_extra_desc"}, 1, 0);
                    got_last = 1'b1;
                end else begin
                    e = expq.pop_front();
                    chk({tag, "_addr"}, int'(m_addr), e.addr);
                    chk({tag, "_mask"}, int'(m_mask), int'(e.mask));
                    chk({tag, "_last"}, int'(m_last), int'(e.last));
                    if (e.last) got_last = 1'b1;
                end
            end
            stalled = m_valid && !ready;
            h_addr = m_addr; h_mask = m_mask; h_last = m_last;
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        chk({tag, "_finished_in_time"}, int'(got_last), 1);
        chk({tag, "_first_latency"}, first_cyc, 2);
        chk({tag, "_done_pulse"}, int'(m_done), 1);
        chk({tag, "_busy_end"}, int'(m_busy), 0);
        chk({tag, "_leftover"}, expq.size(), 0);
        ready = 1'b0;
        @(negedge clk);
        chk({tag, "_done_one_cycle"}, int'(m_done), 0);
        chk({tag, "_valid_after"}, int'(m_valid), 0);
    endtask

    task automatic load_tab1();
        sel = 1'b0; y_addr = AW'(100); inc2m1 = 16'd1; nxm1 = 16'd1;
        ofm_h = 16'd10; n_last = 8'd1;
        expq.delete();
        for (int i = 0; i < 8; i++) expq.push_back(tab1[i]);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"}, int'(m_valid), 0);
        chk({tag, "_addr"}, int'(m_addr), 0);
        chk({tag, "_mask"}, int'(m_mask), 0);
        chk({tag, "_last"}, int'(m_last), 0);
        chk({tag, "_busy"}, int'(m_busy), 0);
        chk({tag, "_done"}, int'(m_done), 0);
    endtask

    initial begin
        int n;
        tab1[0] = '{addr: 100, mask: 1'b0, last: 1'b0};
        tab1[1] = '{addr: 101, mask: 1'b0, last: 1'b0};
        tab1[2] = '{addr: 110, mask: 1'b0, last: 1'b0};
        tab1[3] = '{addr: 111, mask: 1'b0, last: 1'b0};
        tab1[4] = '{addr: 102, mask: 1'b0, last: 1'b0};
        tab1[5] = '{addr: 103, mask: 1'b1, last: 1'b0};
        tab1[6] = '{addr: 112, mask: 1'b0, last: 1'b0};
        tab1[7] = '{addr: 113, mask: 1'b1, last: 1'b1};
        tab3[0] = '{addr: D - 2, mask: 1'b0, last: 1'b0};
        tab3[1] = '{addr: D - 1, mask: 1'b0, last: 1'b0};
        tab3[2] = '{addr: 0,     mask: 1'b0, last: 1'b0};
        tab3[3] = '{addr: 1,     mask: 1'b0, last: 1'b1};

        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        load_tab1();
        do_start();
        drain(100, -1, "basic");

        load_tab1();
        do_start();
        drain(45, -1, "stall");

        sel = 1'b1; y_addr = AW'(D - 2); inc2m1 = 16'd3; nxm1 = 16'd0;
        ofm_h = 16'd1; n_last = 8'd1;
        expq.delete();
        for (int i = 0; i < 4; i++) expq.push_back(tab3[i]);
        do_start();
        drain(100, -1, "wrap_n1_1");

        load_tab1();
        do_start();
        drain(70, 3, "start_busy");

        // Abort while the output is stalled holding a descriptor.
        load_tab1();
        ready = 1'b0;
        do_start();
        n = 0;
        while (!m_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("abort_pre_valid", int'(m_valid), 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_valid", int'(m_valid), 0);
        chk("abort_busy", int'(m_busy), 0);
        chk("abort_done", int'(m_done), 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("abort_no_done", int'(m_done), 0);
        end
        load_tab1();
        do_start();
        drain(100, -1, "after_abort");

        for (int it = 0; it < 12; it++) begin
            sel    = (it % 3 == 2);
            y_addr = AW'($urandom);
            inc2m1 = 16'($urandom_range(0, 3));
            nxm1   = 16'($urandom_range(0, 3));
            ofm_h  = 16'($urandom);
            n_last = 8'($urandom_range(0, 3));
            build_model(sel ? 1 : 2);
            do_start();
            drain($urandom_range(30, 100), -1, "random");
        end

        // Asynchronous reset mid-stream, asserted away from any clock edge.
        load_tab1();
        ready = 1'b0;
        do_start();
        n = 0;
        while (!m_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("arst_pre_valid", int'(m_valid), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("arst");
        @(negedge clk);
        rst_n = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pool_wb_desc_gen.md
# pool_wb_desc_gen

Parametrised write-back descriptor generator for the pooling core. It walks the (x-round, channel-increment, sub-batch) loop nest of one pooling instruction and emits one RTM write descriptor per cycle (address, mask, last) toward the write-back datapath. It supersedes the fixed-width, prog_full-throttled generator with:

- compile-time P/R/RTM geometry;
- a true valid/ready output handshake;
- busy/done status;
- synchronous abort.

## Interface

Parameters:
- `P`, default 16: pooling lanes.
- `R`, default 4: lanes per RTM word; N1 = P/R descriptors per sub-batch, N1 ≥ 1.
- `RTM_DEPTH`, default 8192: RTM words; AW = $clog2(RTM_DEPTH).

Ports:
- `clk`  in  1  core clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  single-cycle start; accepted only when `busy`=0.
- `abort`  in  1  single-cycle abort.
- `Y_addr`  in  AW  output base address.
- `INC2_minus_1`  in  16  channel increments per x-round, minus 1.
- `n_X_rnd_minus_1`  in  16  x-rounds, minus 1.
- `ofm_height`  in  16  address stride between channel increments.
- `n_last_batch`  in  8  valid sub-batch count in the final x-round.
- `desc_valid`  out  1  descriptor valid.
- `desc_ready`  in  1  consumer ready.
- `desc_addr`  out  AW  RTM word address.
- `desc_mask`  out  1  1 = suppress the write.
- `desc_last`  out  1  final descriptor of the instruction.
- `busy`  out  1  instruction in progress.
- `done`  out  1  one-cycle pulse after the last handshake.

## Operation

- Instruction fields are latched on an accepted `start`. Later input changes have no effect until the next start.
- Loop nest, innermost first: n1 in 0..N1-1, inc in 0..INC2_minus_1, x in 0..n_X_rnd_minus_1.
- Descriptor fields:
  - addr = (Y_addr + inc·ofm_height + x·N1 + n1) mod RTM_DEPTH. Compute by accumulation (chan_base += ofm_height; fm_base += N1); use no multipliers.
  - mask = (x == n_X_rnd_minus_1) && (n1 ≥ n_last_batch).
  - last = the final (n1, inc, x) tuple.
- Descriptor count = N1·(INC2_minus_1+1)·(n_X_rnd_minus_1+1). Emission order is strictly the loop order.
- FSM has three states:
  - IDLE: goes to RUN on `start`.
  - RUN: goes to DRAIN once the last tuple enters the pipeline.
  - DRAIN: goes to IDLE after the handshake of the `desc_last` descriptor, asserting `done` for one cycle.
- `abort` in any state:
  - next cycle: state is IDLE, all pipeline valids are cleared, `desc_valid`=0;
  - no `done` is issued;
  - abort has priority over `start` in the same cycle.
- `start` while `busy`=1 is ignored.
- N1=1: n1 is constant 0. Counter widths are $clog2(N1+1).

## Timing

- Reset values: `desc_valid`, `desc_addr`, `desc_mask`, `desc_last`, `busy` and `done` are all 0; FSM is IDLE.
- `busy` rises the cycle after an accepted start and falls in the same cycle `done` is asserted.
- Pipeline has 3 stages: counter → base sum → final add/output register. The first descriptor is valid 3 cycles after the start cycle.
- Throughput is 1 descriptor/cycle while `desc_ready`=1.
- Stalls:
  - a stage advances when its successor is empty or advancing;
  - while `desc_valid`=1 and `desc_ready`=0, the output fields hold stable and no descriptor is lost or duplicated;
  - counters freeze while stalled.
- Handshake is valid&ready in the same cycle. `desc_valid` never depends combinationally on `desc_ready`.
- `done` is asserted the cycle after the last handshake.
- Address wraps modulo RTM_DEPTH silently.

## Structure

- Package `pool_wb_pkg`:
  - `pool_wb_desc_t` {addr[AW], mask, last};
  - the FSM state enum;
  - function N1 = P/R.
- One sub-module, `pool_wb_addr_pipe`: the 3-stage stallable address/mask pipeline with valid/ready. The top level holds the FSM and loop counters.

## Test plan

- P=8, R=4, Y_addr=100, INC2_minus_1=1, n_X_rnd_minus_1=1, ofm_height=10, n_last_batch=1, ready=1 → required response:
  - addrs 100,101,110,111,102,103,112,113;
  - mask only on 103 and 113;
  - last only on 113;
  - `done` one cycle later.
- Same instruction, `desc_ready` toggled pseudo-randomly → identical sequence, fields stable under stall, no gaps or duplicates.
- P=R (N1=1), Y_addr=RTM_DEPTH-2, ofm_height=1, INC2_minus_1=3, n_X_rnd_minus_1=0, n_last_batch=1 → addrs D-2, D-1, 0, 1; no masks; last on 1.
- `abort` mid-RUN with `desc_ready`=0 → `desc_valid`=0 next cycle, `busy`=0, no `done`; a following start runs cleanly from the first descriptor.
- `start` pulsed while busy → ignored, sequence unchanged. `rst_n` asserted mid-stream → all outputs are 0 immediately (asynchronous).
